// File: rtl/des_pkg.sv
// Shared definitions for the nibble scheduler: FSM state encodings and datapath widths.
package des_pkg;

  localparam int NIB_W  = 4;
  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/nibble_scheduler.sv
// Sequences the nibbles of a captured word through an external mux and substitution unit.
// Define NIBBLE_SCHED_MSB_FIRST_EN to walk nibbles from the top index downwards.
module nibble_scheduler
  import des_pkg::*;
#(
  parameter int NIB_N = 8,
  parameter int SEL_W = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [NIB_W*NIB_N-1:0] in_word,
  output logic [NIB_W*NIB_N-1:0] word_q,
  output logic [SEL_W-1:0]       sel,
  output logic                   nib_valid,
  input  logic                   nib_ready,
  input  logic                   res_valid,
  input  logic [NIB_W-1:0]       res_nib,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [NIB_W*NIB_N-1:0] out_word,
  output logic                   busy
);

  localparam int W = NIB_W * NIB_N;

`ifdef NIBBLE_SCHED_MSB_FIRST_EN
  localparam logic [SEL_W-1:0] FIRST_IDX = SEL_W'(NIB_N - 1);
  localparam logic [SEL_W-1:0] LAST_IDX  = {SEL_W{1'b0}};
  // Adding all-ones is a modular decrement.
  localparam logic [SEL_W-1:0] SEL_STEP  = {SEL_W{1'b1}};
`else
  localparam logic [SEL_W-1:0] FIRST_IDX = {SEL_W{1'b0}};
  localparam logic [SEL_W-1:0] LAST_IDX  = SEL_W'(NIB_N - 1);
  localparam logic [SEL_W-1:0] SEL_STEP  = SEL_W'(1'b1);
`endif

  state_t           state_q, state_d;
  logic [SEL_W-1:0] sel_q;
  logic [W-1:0]     out_word_q;
  logic             in_ready_q, nib_valid_q, out_valid_q, busy_q;
  logic             accept_s;

  assign accept_s  = in_valid & in_ready_q;
  assign in_ready  = in_ready_q;
  assign sel       = sel_q;
  assign nib_valid = nib_valid_q;
  assign out_valid = out_valid_q;
  assign out_word  = out_word_q;
  assign busy      = busy_q;

  // Next-state decode; handshake inputs only matter in their own state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_ISSUE;
        else          state_d = ST_IDLE;
      end
      ST_ISSUE: begin
        if (nib_ready) state_d = ST_WAIT;
        else           state_d = ST_ISSUE;
      end
      ST_WAIT: begin
        if (res_valid) begin
          if (sel_q == LAST_IDX) state_d = ST_DONE;
          else                   state_d = ST_ISSUE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
        else           state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, datapath and handshake flags; flags are decoded from the next state so they are registered.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_q       <= {SEL_W{1'b0}};
      word_q      <= {W{1'b0}};
      out_word_q  <= {W{1'b0}};
      in_ready_q  <= 1'b1;
      nib_valid_q <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= (state_d == ST_IDLE);
      nib_valid_q <= (state_d == ST_ISSUE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
      case (state_q)
        ST_IDLE: begin
          if (accept_s) begin
            word_q     <= in_word;
            out_word_q <= {W{1'b0}};
            sel_q      <= FIRST_IDX;
          end
        end
        ST_WAIT: begin
          if (res_valid) begin
            out_word_q[sel_q*NIB_W +: NIB_W] <= res_nib;
            if (sel_q != LAST_IDX) sel_q <= sel_q + SEL_STEP;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_scheduler.sv
// Self-checking bench for nibble_scheduler: vector table plus scoreboard, with hand-written reset
// and stray-result sequences. Honours NIBBLE_SCHED_MSB_FIRST_EN for the expected select order.
module tb_nibble_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, nib_valid, nib_ready;
  logic        res_valid, out_valid, out_ready, busy;
  logic [31:0] in_word, word_q, out_word;
  logic [2:0]  sel;
  logic [3:0]  res_nib;

  int tests_run = 0;
  int tests_failed = 0;
  logic [31:0] sb[$];

  typedef struct {
    logic [31:0] w;
    logic [3:0]  key;
    logic [31:0] exp;
    int          stall_n;
    bit          spur;
    int          ostall_n;
    bit          hold_in;
    int          lat;
  } vec_t;

  vec_t vecs[6];

  nibble_scheduler dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .word_q(word_q), .sel(sel), .nib_valid(nib_valid), .nib_ready(nib_ready),
    .res_valid(res_valid), .res_nib(res_nib), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [2:0] exp_sel(input int i);
`ifdef NIBBLE_SCHED_MSB_FIRST_EN
    return 3'(7 - i);
`else
    return 3'(i);
`endif
  endfunction

  // One complete word transaction with optional issue stall, stray results and DONE stall.
  task automatic run_op(input vec_t v);
    int k, lat, st, ost, nidx;
    bit pend, done;
    logic [31:0] prev_ow, done_ow;
    k = 0;
    while (!in_ready && k < 50) begin
      step();
      k++;
    end
    check("in_ready_before_accept", {31'b0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_word = v.w;
    sb.push_back(v.exp);
    nib_ready = 1'b1; out_ready = 1'b0; res_valid = 1'b0;
    pend = 1'b0; done = 1'b0; lat = 0; st = 0; ost = 0; nidx = 0;
    prev_ow = 32'h0; done_ow = 32'h0;
    step();
    k = 1;
    if (v.hold_in) in_word = ~v.w;
    else           in_valid = 1'b0;
    while (!done && k < 200) begin
      res_valid = 1'b0;
      if (pend) begin
        res_valid = 1'b1;
        res_nib = word_q[sel*4 +: 4] ^ v.key;
      end
      pend = 1'b0;
      check("in_ready_low_busy", {30'b0, in_ready, busy}, 32'd1);
      if (nib_valid) begin
        check("sel_order", {29'b0, sel}, {29'b0, exp_sel(nidx)});
        if (sel == 3'd3 && st < v.stall_n) begin
          nib_ready = 1'b0;
          st++;
          if (v.spur) begin
            res_valid = 1'b1;
            res_nib = ~(word_q[sel*4 +: 4] ^ v.key);
          end
          if (st > 1) check("stall_out_word_stable", out_word, prev_ow);
        end else begin
          nib_ready = 1'b1;
          pend = 1'b1;
          nidx++;
        end
      end
      prev_ow = out_word;
      if (out_valid) begin
        if (lat == 0) begin
          lat = k;
          done_ow = out_word;
          check("latency", lat, v.lat);
          check("nibbles_issued", nidx, 32'd8);
        end else begin
          check("done_word_stable", out_word, done_ow);
        end
        if (ost < v.ostall_n) begin
          out_ready = 1'b0;
          ost++;
        end else begin
          out_ready = 1'b1;
          if (sb.size() > 0) check("result", out_word, sb.pop_front());
          else               check("scoreboard_empty", 32'd0, 32'd1);
          done = 1'b1;
        end
      end
      step();
      k++;
    end
    if (!done) check("op_timeout", 32'd0, 32'd1);
    out_ready = 1'b0;
    res_valid = 1'b0;
    check("idle_after_done", {30'b0, in_ready, busy}, 32'd2);
  endtask

  initial begin
    logic [31:0] last_ow;
    bit pend, found;

    vecs[0] = '{32'h89ABCDEF, 4'hF, 32'h76543210, 0, 1'b0, 0, 1'b0, 17};
    vecs[1] = '{32'h00000000, 4'h5, 32'h55555555, 0, 1'b0, 0, 1'b0, 17};
    vecs[2] = '{32'h12345678, 4'h3, 32'h2107654B, 5, 1'b1, 0, 1'b0, 22};
    vecs[3] = '{32'hA5A5A5A5, 4'hA, 32'h0F0F0F0F, 0, 1'b0, 4, 1'b1, 17};
    vecs[4] = '{32'hFFFFFFFF, 4'h0, 32'hFFFFFFFF, 0, 1'b0, 0, 1'b0, 17};
    vecs[5] = '{32'hDEADBEEF, 4'hF, 32'h21524110, 0, 1'b0, 0, 1'b0, 17};

    rst_n = 1'b0; in_valid = 1'b0; in_word = 32'h0; nib_ready = 1'b0;
    res_valid = 1'b0; res_nib = 4'h0; out_ready = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_flags", {29'b0, busy, nib_valid, out_valid}, 32'd0);
    check("rst_sel", {29'b0, sel}, 32'd0);
    check("rst_word_q", word_q, 32'd0);
    check("rst_out_word", out_word, 32'd0);

    for (int i = 0; i < 6; i++) run_op(vecs[i]);
    in_valid = 1'b0;

    // Stray result in IDLE must not touch the held result or select.
    last_ow = out_word;
    res_valid = 1'b1;
    res_nib = 4'h3;
    step();
    res_valid = 1'b0;
    step();
    check("idle_res_ignored_word", out_word, last_ow);
    check("idle_res_ignored_sel", {29'b0, sel}, {29'b0, exp_sel(7)});
    check("idle_res_ignored_busy", {31'b0, busy}, 32'd0);

    // Reset while waiting for the result of nibble 5.
    in_valid = 1'b1;
    in_word = 32'h13579BDF;
    nib_ready = 1'b1;
    step();
    in_valid = 1'b0;
    pend = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (busy && !nib_valid && !out_valid && sel == 3'd5) begin
        found = 1'b1;
      end else begin
        res_valid = pend;
        res_nib = word_q[sel*4 +: 4] ^ 4'h6;
        pend = nib_valid;
        step();
      end
    end
    check("reached_wait_sel5", {31'b0, found}, 32'd1);
    rst_n = 1'b0;
    res_valid = 1'b1;
    res_nib = 4'h9;
    step();
    rst_n = 1'b1;
    check("midrst_in_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_flags", {29'b0, busy, nib_valid, out_valid}, 32'd0);
    check("midrst_sel", {29'b0, sel}, 32'd0);
    check("midrst_word_q", word_q, 32'd0);
    check("midrst_out_word", out_word, 32'd0);
    res_nib = 4'hF;
    step();
    res_valid = 1'b0;
    step();
    check("postrst_res_ignored_word", out_word, 32'd0);
    check("postrst_res_ignored_sel", {29'b0, sel}, 32'd0);
    check("postrst_idle", {30'b0, in_ready, busy}, 32'd2);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/nibble_scheduler.md
NIBBLE_SCHEDULER -- requirements
Module: nibble_scheduler

Interface
REQ-001 Parameter NIB_N, default 8: nibbles per word; word width is 4*NIB_N.
REQ-002 Parameter SEL_W, default 3: select width, equal to clog2(NIB_N).
REQ-003 The block SHALL use one clock; reset is synchronous and active-low.
REQ-004 clk  in  1  rising-edge clock.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 in_valid  in  1  / in_ready  out  1 / in_word  in  32: word-load handshake.
REQ-007 word_q  out  32  captured word, drives the external 8:1 nibble mux data input.
REQ-008 sel  out  SEL_W  drives the external nibble mux select.
REQ-009 nib_valid  out  1 / nib_ready  in  1: issue of the mux nibble to the shared substitution unit.
REQ-010 res_valid  in  1 / res_nib  in  4: processed nibble returned from the substitution unit.
REQ-011 out_valid  out  1 / out_ready  in  1 / out_word  out  32: result handshake.
REQ-012 busy  out  1  high in every state except IDLE.

Function
REQ-013 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE.
REQ-014 IDLE: in_ready=1; on in_valid&in_ready, word_q<=in_word, out_word<=0, sel<=first index, next state ISSUE.
REQ-015 ISSUE: nib_valid=1 with sel stable; on nib_ready, next state WAIT; otherwise hold the state.
REQ-016 WAIT: on res_valid, out_word[4*sel+3:4*sel]<=res_nib; if sel==last index, next state DONE, else sel advances by one and next state ISSUE.
REQ-017 DONE: out_valid=1 and out_word stable; on out_ready, next state IDLE; otherwise hold the state.
REQ-018 res_valid outside WAIT SHALL be ignored with no state or data change.
REQ-019 in_valid outside IDLE SHALL be ignored; in_ready=0 outside IDLE.
REQ-020 Default order: first index 0, last index 7, sel increments.
REQ-021 Minimum latency, with nib_ready and res_valid high at the first opportunity: out_valid asserts 17 cycles after the accept edge.
REQ-022 sel and word_q SHALL change only on accept or on a WAIT completion, never combinationally from the inputs.
REQ-023 Back-to-back operation: a new accept is possible no earlier than the cycle after the DONE handshake.
REQ-024 All handshake outputs SHALL be registered-state decodes, with no combinational path from any input to any output.

Reset
REQ-025 When rst_n=0 at a rising edge, the block SHALL enter IDLE with sel=0, word_q=0, out_word=0, nib_valid=0, out_valid=0, busy=0 and in_ready=1.
REQ-026 Reset mid-operation SHALL abandon the word; a res_valid arriving after reset SHALL be ignored.

Configuration
REQ-027 Macro NIBBLE_SCHED_MSB_FIRST_EN: when defined, first index = 7, last index = 0, and sel decrements.
REQ-028 When NIBBLE_SCHED_MSB_FIRST_EN is undefined, the order SHALL be LSB-first per REQ-020.
REQ-029 Both orders SHALL produce an identical out_word for identical per-nibble results.

Structure
REQ-030 The shared package des_pkg SHALL hold the state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT=2'd2, DONE=2'd3), NIB_W=4 and WORD_W=32.
REQ-031 No sub-module is required; the 8:1 nibble mux and the substitution unit SHALL remain external, driven by word_q, sel and nib_valid.

Verification
REQ-032 in_word=32'h89ABCDEF, substitution unit returns nibble XOR 4'hF, all ready signals high -> out_word=32'h76543210, out_valid at cycle 17.
REQ-033 nib_ready held low 5 cycles on nibble 3 -> sel holds 3 and nib_valid holds 1 for those cycles; result unchanged; latency 22.
REQ-034 res_valid pulsed during ISSUE and IDLE -> no out_word change and no sel advance.
REQ-035 out_ready low 4 cycles in DONE with in_valid high -> out_word stable, in_ready=0, second word accepted only after the DONE handshake.
REQ-036 rst_n=0 while in WAIT at sel=5 -> next cycle IDLE, all outputs at reset values, later res_valid ignored.
REQ-037 With NIBBLE_SCHED_MSB_FIRST_EN defined -> sel sequence 7..0, same out_word as REQ-032.
